// File: rtl/memory_dram_bridge.sv
// rtl/memory_dram_bridge.sv - PDP-6 core-memory slave to 64-bit pipelined Avalon master bridge
// Writes are posted through a small FIFO; a read waits for the FIFO to drain, then issues one master read.
module memory_dram_bridge #(
   parameter int          ADDR_W     = 18,
   parameter int          DATA_W     = 36,
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          WBUF_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [ADDR_W-1:0]           s_address,
   input  logic                        s_write,
   input  logic                        s_read,
   input  logic [DATA_W-1:0]           s_writedata,
   output logic [DATA_W-1:0]           s_readdata,
   output logic                        s_waitrequest,
   output logic [31:0]                 m_address,
   output logic                        m_write,
   output logic                        m_read,
   output logic [63:0]                 m_writedata,
   input  logic [63:0]                 m_readdata,
   input  logic                        m_waitrequest,
   input  logic                        m_readdatavalid,
   output logic [$clog2(WBUF_DEPTH):0] wbuf_count
);
   localparam int PTR_W = $clog2(WBUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD_CMD, ST_RD_WAIT, ST_RD_DONE} state_t;
   state_t r_state, w_state_nxt;

   logic [ADDR_W-1:0] r_fifo_addr [WBUF_DEPTH];
   logic [DATA_W-1:0] r_fifo_data [WBUF_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]  r_count, w_count_nxt;
   logic [ADDR_W-1:0] r_rd_addr, w_addr_sel;
   logic [DATA_W-1:0] r_readdata, w_head_data;
   logic              w_full, w_empty, w_push, w_pop, w_rd_phase, w_unused_rdata;

   // Fullness uses the registered count, so a full buffer refuses a push even while popping.
   assign w_full         = (r_count == CNT_W'(WBUF_DEPTH));
   assign w_empty        = (r_count == '0);
   assign w_push         = s_write & ~s_read & ~w_full;
   assign w_pop          = (r_state == ST_WR) & ~m_waitrequest;
   assign w_count_nxt    = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
   assign w_unused_rdata = ^m_readdata;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= s_address;
         r_fifo_data[r_wr_ptr] <= s_writedata;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_rd_addr  <= '0;
         r_readdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && w_empty && s_read) r_rd_addr <= s_address;
         if (r_state == ST_RD_WAIT && m_readdatavalid) r_readdata <= m_readdata[DATA_W-1:0];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty)    w_state_nxt = ST_WR;
            else if (s_read) w_state_nxt = ST_RD_CMD;
         end
         ST_WR:      if (w_pop && w_count_nxt == '0) w_state_nxt = ST_IDLE;
         ST_RD_CMD:  if (!m_waitrequest)             w_state_nxt = ST_RD_WAIT;
         ST_RD_WAIT: if (m_readdatavalid)            w_state_nxt = ST_RD_DONE;
         ST_RD_DONE: w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // An empty FIFO presents a zero head so the master bus idles at BASE_ADDR with zero data.
   assign w_rd_phase  = (r_state == ST_RD_CMD) || (r_state == ST_RD_WAIT) || (r_state == ST_RD_DONE);
   assign w_head_data = w_empty ? '0 : r_fifo_data[r_rd_ptr];
   assign w_addr_sel  = w_rd_phase ? r_rd_addr : (w_empty ? '0 : r_fifo_addr[r_rd_ptr]);

   assign m_address     = BASE_ADDR | 32'({w_addr_sel, 3'b000});
   assign m_writedata   = 64'(w_head_data);
   assign m_write       = (r_state == ST_WR);
   assign m_read        = (r_state == ST_RD_CMD);
   assign s_readdata    = r_readdata;
   assign s_waitrequest = s_read ? (r_state != ST_RD_DONE) : (s_write & w_full);
   assign wbuf_count    = r_count;
endmodule

// File: tb/tb_memory_dram_bridge.sv
// tb/tb_memory_dram_bridge.sv - self-checking bench for memory_dram_bridge
// A DRAM model answers the master port; a reference memory predicts every read result.
module tb_memory_dram_bridge;
   localparam int          ADDR_W = 18;
   localparam int          DATA_W = 36;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] BASE   = 32'h3000_0000;
   localparam int          MEM_N  = 1024;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [ADDR_W-1:0] s_address = '0;
   logic              s_write = 1'b0, s_read = 1'b0;
   logic [DATA_W-1:0] s_writedata = '0;
   logic [DATA_W-1:0] s_readdata;
   logic              s_waitrequest;
   logic [31:0]       m_address;
   logic              m_write, m_read;
   logic [63:0]       m_writedata;
   logic [63:0]       m_readdata = '0;
   logic              m_waitrequest = 1'b0, m_readdatavalid = 1'b0;
   logic [2:0]        wbuf_count;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   int          n_checks = 0, n_fails = 0, n_mwrites = 0;
   wr_t         exp_q[$];
   logic [63:0] dram    [MEM_N];
   logic [63:0] ref_mem [MEM_N];
   bit          rand_wait = 1'b0;
   int          rd_lat = 1, rd_cnt = 0, rd_idx = 0;

   memory_dram_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE), .WBUF_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .s_address(s_address), .s_write(s_write), .s_read(s_read),
      .s_writedata(s_writedata), .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
      .m_address(m_address), .m_write(m_write), .m_read(m_read), .m_writedata(m_writedata),
      .m_readdata(m_readdata), .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid),
      .wbuf_count(wbuf_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // DRAM model and scoreboard: observes transfers mid-cycle, drives responses just after the edge.
   initial begin
      wr_t e;
      wr_t p;
      for (int i = 0; i < MEM_N; i++) begin
         dram[i]    = {$urandom, $urandom};
         ref_mem[i] = dram[i];
      end
      forever begin
         @(negedge clk);
         n_checks++; if (m_read && m_write) begin n_fails++; $display("FAIL rw_exclusive: m_read=%0b m_write=%0b, required not both 1", m_read, m_write); end
         if (m_write && !m_waitrequest) begin
            n_mwrites++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fails++; $display("FAIL unexpected_mwrite: addr=%h data=%h, required no master write", m_address, m_writedata);
            end else begin
               e = exp_q.pop_front();
               if (m_address !== (BASE | (32'(e.addr) << 3)) || m_writedata !== 64'(e.data)) begin
                  n_fails++; $display("FAIL mwrite_order: addr=%h data=%h, required addr=%h data=%h", m_address, m_writedata, BASE | (32'(e.addr) << 3), 64'(e.data));
               end
            end
            dram[m_address[12:3]] = m_writedata;
         end
         if (m_read && !m_waitrequest) begin
            n_checks++; if (rd_cnt != 0) begin n_fails++; $display("FAIL read_outstanding: pending=%0d, required 0", rd_cnt); end
            rd_cnt = rd_lat;
            rd_idx = int'(m_address[12:3]);
         end
         if (reset && s_write && !s_read && !s_waitrequest) begin
            p.addr = s_address;
            p.data = s_writedata;
            exp_q.push_back(p);
            ref_mem[s_address[9:0]] = 64'(s_writedata);
         end
         if (!reset) begin
            exp_q.delete();
            rd_cnt = 0;
            for (int i = 0; i < MEM_N; i++) ref_mem[i] = dram[i];
         end
         @(posedge clk);
         #1;
         if (rand_wait) m_waitrequest = 1'($urandom_range(0, 1));
         m_readdatavalid = 1'b0;
         if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               m_readdatavalid = 1'b1;
               m_readdata = {28'($urandom), dram[rd_idx][35:0]};
            end
         end else if (rand_wait && $urandom_range(0, 7) == 0) begin
            m_readdatavalid = 1'b1;
            m_readdata = {$urandom, $urandom};
         end
      end
   end

   task automatic test_reset();
      reset = 1'b0; s_write = 1'b0; s_read = 1'b0; m_waitrequest = 1'b0;
      tick(); tick();
      n_checks++; if (m_write !== 1'b0) begin n_fails++; $display("FAIL reset_m_write: got %0b required 0", m_write); end
      n_checks++; if (m_read !== 1'b0) begin n_fails++; $display("FAIL reset_m_read: got %0b required 0", m_read); end
      n_checks++; if (wbuf_count !== 3'd0) begin n_fails++; $display("FAIL reset_wbuf_count: got %0d required 0", wbuf_count); end
      n_checks++; if (s_readdata !== '0) begin n_fails++; $display("FAIL reset_s_readdata: got %h required 0", s_readdata); end
      n_checks++; if (m_address !== BASE) begin n_fails++; $display("FAIL reset_m_address: got %h required %h", m_address, BASE); end
      n_checks++; if (m_writedata !== 64'd0) begin n_fails++; $display("FAIL reset_m_writedata: got %h required 0", m_writedata); end
      n_checks++; if (s_waitrequest !== 1'b0) begin n_fails++; $display("FAIL reset_s_waitrequest: got %0b required 0", s_waitrequest); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_posted_write();
      logic [ADDR_W-1:0] a = 18'o1234;
      logic [DATA_W-1:0] d = 36'o777000111222;
      m_waitrequest = 1'b0;
      s_write = 1'b1; s_address = a; s_writedata = d;
      #3;
      n_checks++; if (s_waitrequest !== 1'b0) begin n_fails++; $display("FAIL posted_no_stall: got %0b required 0", s_waitrequest); end
      tick(); s_write = 1'b0; #3;
      n_checks++; if (m_write !== 1'b0 || wbuf_count !== 3'd1) begin n_fails++; $display("FAIL posted_cycle1: m_write=%0b count=%0d, required 0 and 1", m_write, wbuf_count); end
      tick(); #3;
      n_checks++; if (m_write !== 1'b1) begin n_fails++; $display("FAIL posted_m_write: got %0b required 1", m_write); end
      n_checks++; if (m_address !== (BASE | (32'(a) << 3))) begin n_fails++; $display("FAIL posted_m_address: got %h required %h", m_address, BASE | (32'(a) << 3)); end
      n_checks++; if (m_writedata !== {28'd0, d}) begin n_fails++; $display("FAIL posted_m_writedata: got %h required %h", m_writedata, {28'd0, d}); end
      tick(); #3;
      n_checks++; if (wbuf_count !== 3'd0 || m_write !== 1'b0) begin n_fails++; $display("FAIL posted_drained: count=%0d m_write=%0b, required 0 and 0", wbuf_count, m_write); end
   endtask

   task automatic test_full_buffer();
      int  base_w;
      bit  drained = 1'b0;
      tick();
      base_w = n_mwrites;
      m_waitrequest = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s_write = 1'b1; s_address = ADDR_W'(100 + i); s_writedata = DATA_W'({$urandom, $urandom});
         #3;
         n_checks++; if (s_waitrequest !== (i == 4)) begin n_fails++; $display("FAIL full_accept_%0d: waitrequest=%0b required %0b", i, s_waitrequest, i == 4); end
         if (i < 4) tick();
      end
      n_checks++; if (wbuf_count !== 3'd4) begin n_fails++; $display("FAIL full_count: got %0d required 4", wbuf_count); end
      tick(); tick(); #3;
      n_checks++; if (s_waitrequest !== 1'b1 || m_write !== 1'b1) begin n_fails++; $display("FAIL full_hold: waitrequest=%0b m_write=%0b, required 1 and 1", s_waitrequest, m_write); end
      tick(); m_waitrequest = 1'b0; #3;
      n_checks++; if (s_waitrequest !== 1'b1) begin n_fails++; $display("FAIL full_pop_same_cycle: waitrequest=%0b required 1", s_waitrequest); end
      tick(); #3;
      n_checks++; if (s_waitrequest !== 1'b0 || wbuf_count !== 3'd3) begin n_fails++; $display("FAIL full_fifth_accept: waitrequest=%0b count=%0d, required 0 and 3", s_waitrequest, wbuf_count); end
      tick(); s_write = 1'b0;
      for (int c = 0; c < 20 && !drained; c++) begin
         #3;
         if (wbuf_count == 3'd0 && !m_write) drained = 1'b1; else tick();
      end
      n_checks++; if (!drained) begin n_fails++; $display("FAIL full_drain_timeout: count=%0d, required 0 within 20 cycles", wbuf_count); end
      n_checks++; if (n_mwrites - base_w != 5 || exp_q.size() != 0) begin n_fails++; $display("FAIL full_all_written: writes=%0d left=%0d, required 5 and 0", n_mwrites - base_w, exp_q.size()); end
   endtask

   task automatic test_read_after_write();
      logic [DATA_W-1:0] d = DATA_W'({$urandom, $urandom});
      bit saw_w = 1'b0, bad_order = 1'b0, done = 1'b0;
      int n = 0;
      tick();
      m_waitrequest = 1'b0; rd_lat = 3;
      s_write = 1'b1; s_address = 18'd5; s_writedata = d;
      tick();
      s_write = 1'b0; s_read = 1'b1;
      for (int c = 0; c < 30 && !done; c++) begin
         #3;
         if (m_write) saw_w = 1'b1;
         if (m_read && !saw_w) bad_order = 1'b1;
         if (!s_waitrequest) done = 1'b1; else tick();
      end
      n_checks++; if (!done || !saw_w || bad_order) begin n_fails++; $display("FAIL raw_order: done=%0b saw_write=%0b read_first=%0b, required 1 1 0", done, saw_w, bad_order); end
      n_checks++; if (s_readdata !== d) begin n_fails++; $display("FAIL raw_data: got %h required %h", s_readdata, d); end
      tick(); #3;
      n_checks++; if (s_waitrequest !== 1'b1) begin n_fails++; $display("FAIL raw_one_cycle: waitrequest=%0b required 1", s_waitrequest); end
      while (s_waitrequest && n < 30) begin tick(); n++; #3; end
      n_checks++; if (n != 2 + rd_lat) begin n_fails++; $display("FAIL read_latency: got %0d cycles required %0d", n, 2 + rd_lat); end
      n_checks++; if (s_readdata !== ref_mem[5][DATA_W-1:0]) begin n_fails++; $display("FAIL reread_data: got %h required %h", s_readdata, ref_mem[5][DATA_W-1:0]); end
      tick(); s_read = 1'b0;
   endtask

   task automatic test_stalled_read();
      logic [ADDR_W-1:0] a = 18'd7;
      logic [31:0] a0;
      int n = 0;
      tick();
      m_waitrequest = 1'b1; rd_lat = 2;
      s_read = 1'b1; s_address = a;
      tick(); #3;
      a0 = m_address;
      n_checks++; if (m_read !== 1'b1 || a0 !== (BASE | (32'(a) << 3))) begin n_fails++; $display("FAIL stall_cmd: m_read=%0b addr=%h, required 1 and %h", m_read, a0, BASE | (32'(a) << 3)); end
      for (int k = 0; k < 3; k++) begin
         tick(); #1;
         m_readdatavalid = 1'b1; m_readdata = {28'd0, ~ref_mem[a][DATA_W-1:0]};
         #2;
         n_checks++; if (m_read !== 1'b1 || m_address !== a0) begin n_fails++; $display("FAIL stall_stable_%0d: m_read=%0b addr=%h, required 1 and %h", k, m_read, m_address, a0); end
      end
      tick(); m_waitrequest = 1'b0; #3;
      while (s_waitrequest && n < 30) begin tick(); n++; #3; end
      n_checks++; if (s_waitrequest !== 1'b0) begin n_fails++; $display("FAIL stall_timeout: waitrequest=%0b required 0", s_waitrequest); end
      n_checks++; if (s_readdata !== ref_mem[a][DATA_W-1:0]) begin n_fails++; $display("FAIL stall_stray_ignored: got %h required %h", s_readdata, ref_mem[a][DATA_W-1:0]); end
      tick(); s_read = 1'b0;
   endtask

   task automatic test_reset_mid();
      int base_w;
      tick();
      m_waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_write = 1'b1; s_address = ADDR_W'(200 + i); s_writedata = DATA_W'({$urandom, $urandom});
         tick();
      end
      s_write = 1'b0; reset = 1'b0; #3;
      n_checks++; if (wbuf_count !== 3'd3) begin n_fails++; $display("FAIL rstmid_buffered: got %0d required 3", wbuf_count); end
      base_w = n_mwrites;
      tick(); reset = 1'b1; #3;
      n_checks++; if (wbuf_count !== 3'd0 || m_write !== 1'b0) begin n_fails++; $display("FAIL rstmid_cleared: count=%0d m_write=%0b, required 0 and 0", wbuf_count, m_write); end
      m_waitrequest = 1'b0;
      repeat (8) tick();
      n_checks++; if (n_mwrites != base_w) begin n_fails++; $display("FAIL rstmid_discarded: %0d writes appeared, required 0", n_mwrites - base_w); end
   endtask

   task automatic test_random();
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] got;
      bit ok;
      rand_wait = 1'b1;
      for (int n = 0; n < 300; n++) begin
         int op = $urandom_range(0, 9);
         rd_lat = $urandom_range(1, 4);
         a = ADDR_W'($urandom_range(0, 15));
         ok = 1'b0;
         if (op < 5) begin
            s_write = 1'b1; s_address = a; s_writedata = DATA_W'({$urandom, $urandom});
            for (int c = 0; c < 50 && !ok; c++) begin #3; if (!s_waitrequest) ok = 1'b1; tick(); end
            s_write = 1'b0;
            n_checks++; if (!ok) begin n_fails++; $display("FAIL rand_write_timeout: op %0d addr %0d, required acceptance within 50 cycles", n, a); end
         end else if (op < 8) begin
            s_read = 1'b1; s_address = a; got = '0;
            for (int c = 0; c < 80 && !ok; c++) begin #3; if (!s_waitrequest) begin ok = 1'b1; got = s_readdata; end tick(); end
            s_read = 1'b0;
            n_checks++; if (!ok || got !== ref_mem[a[9:0]][DATA_W-1:0]) begin n_fails++; $display("FAIL rand_read: op %0d addr %0d done=%0b got %h required %h", n, a, ok, got, ref_mem[a[9:0]][DATA_W-1:0]); end
         end else begin
            tick();
         end
      end
      rand_wait = 1'b0; m_waitrequest = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin #3; if (wbuf_count == 3'd0 && !m_write) ok = 1'b1; else tick(); end
      n_checks++; if (!ok || exp_q.size() != 0) begin n_fails++; $display("FAIL rand_drain: count=%0d left=%0d, required 0 and 0", wbuf_count, exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_posted_write();
      test_full_buffer();
      test_read_after_write();
      test_stalled_read();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #400000;
      n_fails++;
      $display("FAIL watchdog: time limit reached, required completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $fatal(1);
   end
endmodule
